bp_be_retire_pair_ctrl: RTL and testbench

Dual-lane retire sequencer for the dual-issue backend. It tracks both issue lanes through a fixed-depth shadow pipeline and enforces in-order retirement: lane 1 is always the older instruction. It squashes lane 2 behind a trapping or serializing lane 1 and applies flushes. Its outputs drive the `retire_*` / `retire_*2` inputs of `bp_be_pipe_sys` directly.

---
 rtl/bp_be_retire_pair_ctrl.sv | 150 +++++++++++++++
 tb/tb_bp_be_retire_pair_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_retire_pair_ctrl.sv
// Dual-lane in-order retire sequencer: shadows both issue lanes to the retire stage,
// squashes lane 2 behind a trapping/serializing lane 1, and applies kill/flush.
module bp_be_retire_pair_ctrl
  #(parameter int dpath_width_gp     = 64
  , parameter int retire_stages_p    = 4
  , parameter int exception_width_lp = 16
  , parameter int special_width_lp   = 8
  )
  (input  logic                          clk_i
  , input  logic                          reset_i
  , input  logic                          issue_v_i
  , input  logic                          issue_v_i2
  , input  logic                          issue_queue_v_i
  , input  logic                          issue_queue_v_i2
  , input  logic [exception_width_lp-1:0] issue_exception_i
  , input  logic [exception_width_lp-1:0] issue_exception_i2
  , input  logic                          late_exception_v_i
  , input  logic                          late_exception_v_i2
  , input  logic [exception_width_lp-1:0] late_exception_i
  , input  logic [exception_width_lp-1:0] late_exception_i2
  , input  logic [special_width_lp-1:0]   issue_special_i
  , input  logic [special_width_lp-1:0]   issue_special_i2
  , input  logic [dpath_width_gp-1:0]     wb_data_i
  , input  logic [dpath_width_gp-1:0]     wb_data_i2
  , input  logic                          flush_i
  , output logic                          retire_v_o
  , output logic                          retire_v_o2
  , output logic                          retire_queue_v_o
  , output logic                          retire_queue_v_o2
  , output logic [dpath_width_gp-1:0]     retire_data_o
  , output logic [dpath_width_gp-1:0]     retire_data_o2
  , output logic [exception_width_lp-1:0] retire_exception_o
  , output logic [exception_width_lp-1:0] retire_exception_o2
  , output logic [special_width_lp-1:0]   retire_special_o
  , output logic [special_width_lp-1:0]   retire_special_o2
  , output logic                          kill_o
  , output logic [1:0]                    retire_count_o
  , output logic [63:0]                   instret_o
  );

  localparam int last_lp = retire_stages_p - 1;
  localparam int late_lp = retire_stages_p - 2;

  // Index 0 is lane 1 (older), index 1 is lane 2.
  logic [1:0][retire_stages_p-1:0]                         v_r, v_nxt_s;
  logic [1:0][retire_stages_p-1:0]                         q_r, q_nxt_s;
  logic [1:0][retire_stages_p-1:0][exception_width_lp-1:0] exc_r, exc_nxt_s;
  logic [1:0][retire_stages_p-1:0][special_width_lp-1:0]   spec_r, spec_nxt_s;
  logic [63:0]                                             instret_r;

  logic [1:0]                         issue_v_s, issue_q_s, late_v_s;
  logic [1:0][exception_width_lp-1:0] issue_exc_s, late_exc_s;
  logic [1:0][special_width_lp-1:0]   issue_spec_s;
  logic                               ser_s, go2_s, clear_s;
  logic                               inc1_s, inc2_s;
  logic [1:0]                         inc_s;

  assign issue_v_s    = {issue_v_i2, issue_v_i};
  assign issue_q_s    = {issue_queue_v_i2, issue_queue_v_i};
  assign issue_exc_s  = {issue_exception_i2, issue_exception_i};
  assign issue_spec_s = {issue_special_i2, issue_special_i};
  assign late_v_s     = {late_exception_v_i2, late_exception_v_i};
  assign late_exc_s   = {late_exception_i2, late_exception_i};

  // Serialize/squash decision from the retire-stage entries.
  always_comb begin
    ser_s  = v_r[0][last_lp] & ((|exc_r[0][last_lp]) | (|spec_r[0][last_lp]));
    go2_s  = v_r[1][last_lp] & ~ser_s;
    inc1_s = v_r[0][last_lp] & ~(|exc_r[0][last_lp]);
    inc2_s = go2_s & ~(|exc_r[1][last_lp]);
  end

  // A kill or flush drops every entry behind the retire stage plus this cycle's issue.
  assign clear_s = ser_s | flush_i;
  assign inc_s   = {1'b0, inc1_s} + {1'b0, inc2_s};

  // Shadow pipeline next state, with late exceptions merged on the way into the retire stage.
  always_comb begin
    v_nxt_s    = v_r;
    q_nxt_s    = q_r;
    exc_nxt_s  = exc_r;
    spec_nxt_s = spec_r;
    for (int l = 0; l < 2; l++) begin
      v_nxt_s[l][0]    = issue_v_s[l] & ~clear_s;
      q_nxt_s[l][0]    = issue_q_s[l];
      exc_nxt_s[l][0]  = issue_exc_s[l];
      spec_nxt_s[l][0] = issue_spec_s[l];
      for (int s = 1; s < retire_stages_p; s++) begin
        v_nxt_s[l][s]    = v_r[l][s-1] & ~clear_s;
        q_nxt_s[l][s]    = q_r[l][s-1];
        exc_nxt_s[l][s]  = exc_r[l][s-1];
        spec_nxt_s[l][s] = spec_r[l][s-1];
      end
      exc_nxt_s[l][last_lp] = exc_r[l][late_lp]
                              | (late_v_s[l] ? late_exc_s[l] : {exception_width_lp{1'b0}});
    end
  end

  // Stage registers and retired-instruction counter.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      v_r       <= '0;
      q_r       <= '0;
      exc_r     <= '0;
      spec_r    <= '0;
      instret_r <= 64'd0;
    end else begin
      v_r       <= v_nxt_s;
      q_r       <= q_nxt_s;
      exc_r     <= exc_nxt_s;
      spec_r    <= spec_nxt_s;
      instret_r <= instret_r + {62'd0, inc_s};
    end
  end

  // Retire outputs are combinational from the retire stage and writeback data.
  always_comb begin
    retire_v_o       = v_r[0][last_lp];
    retire_queue_v_o = v_r[0][last_lp] & q_r[0][last_lp];
    retire_data_o    = wb_data_i;
    if (v_r[0][last_lp]) begin
      retire_exception_o = exc_r[0][last_lp];
    end else begin
      retire_exception_o = {exception_width_lp{1'b0}};
    end
    if (v_r[0][last_lp] & ~(|exc_r[0][last_lp])) begin
      retire_special_o = spec_r[0][last_lp];
    end else begin
      retire_special_o = {special_width_lp{1'b0}};
    end
    if (go2_s) begin
      retire_v_o2         = 1'b1;
      retire_queue_v_o2   = q_r[1][last_lp];
      retire_data_o2      = wb_data_i2;
      retire_exception_o2 = exc_r[1][last_lp];
      retire_special_o2   = spec_r[1][last_lp];
    end else begin
      retire_v_o2         = 1'b0;
      retire_queue_v_o2   = 1'b0;
      retire_data_o2      = {dpath_width_gp{1'b0}};
      retire_exception_o2 = {exception_width_lp{1'b0}};
      retire_special_o2   = {special_width_lp{1'b0}};
    end
  end

  assign kill_o         = ser_s;
  assign retire_count_o = {1'b0, retire_v_o} + {1'b0, retire_v_o2};
  assign instret_o      = instret_r;

endmodule

// File: tb/tb_bp_be_retire_pair_ctrl.sv
// Scoreboard bench for bp_be_retire_pair_ctrl: directed issue patterns push expected
// retire responses; a negedge monitor pops and compares whenever a lane retires.
module tb_bp_be_retire_pair_ctrl;
  localparam int DW = 64;
  localparam int NS = 4;
  localparam int EW = 16;
  localparam int SW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          issue_v_i, issue_v_i2, issue_queue_v_i, issue_queue_v_i2;
  logic [EW-1:0] issue_exception_i, issue_exception_i2;
  logic          late_exception_v_i, late_exception_v_i2;
  logic [EW-1:0] late_exception_i, late_exception_i2;
  logic [SW-1:0] issue_special_i, issue_special_i2;
  logic [DW-1:0] wb_data_i, wb_data_i2;
  logic          flush_i;
  logic          retire_v_o, retire_v_o2, retire_queue_v_o, retire_queue_v_o2;
  logic [DW-1:0] retire_data_o, retire_data_o2;
  logic [EW-1:0] retire_exception_o, retire_exception_o2;
  logic [SW-1:0] retire_special_o, retire_special_o2;
  logic          kill_o;
  logic [1:0]    retire_count_o;
  logic [63:0]   instret_o;

  bp_be_retire_pair_ctrl #(.dpath_width_gp(DW), .retire_stages_p(NS),
                           .exception_width_lp(EW), .special_width_lp(SW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .issue_v_i(issue_v_i), .issue_v_i2(issue_v_i2),
    .issue_queue_v_i(issue_queue_v_i), .issue_queue_v_i2(issue_queue_v_i2),
    .issue_exception_i(issue_exception_i), .issue_exception_i2(issue_exception_i2),
    .late_exception_v_i(late_exception_v_i), .late_exception_v_i2(late_exception_v_i2),
    .late_exception_i(late_exception_i), .late_exception_i2(late_exception_i2),
    .issue_special_i(issue_special_i), .issue_special_i2(issue_special_i2),
    .wb_data_i(wb_data_i), .wb_data_i2(wb_data_i2), .flush_i(flush_i),
    .retire_v_o(retire_v_o), .retire_v_o2(retire_v_o2),
    .retire_queue_v_o(retire_queue_v_o), .retire_queue_v_o2(retire_queue_v_o2),
    .retire_data_o(retire_data_o), .retire_data_o2(retire_data_o2),
    .retire_exception_o(retire_exception_o), .retire_exception_o2(retire_exception_o2),
    .retire_special_o(retire_special_o), .retire_special_o2(retire_special_o2),
    .kill_o(kill_o), .retire_count_o(retire_count_o), .instret_o(instret_o));

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          v1, q1;
    logic [EW-1:0] e1;
    logic [SW-1:0] s1;
    logic          v2, q2;
    logic [EW-1:0] e2;
    logic [SW-1:0] s2;
    logic          kill;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        mon_en = 1'b0;
  logic [31:0] cyc = 32'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic v1, q1, input logic [EW-1:0] e1, input logic [SW-1:0] s1,
                              input logic v2, q2, input logic [EW-1:0] e2, input logic [SW-1:0] s2,
                              input logic kill);
    exp_t e;
    e = '{v1:v1, q1:q1, e1:e1, s1:s1, v2:v2, q2:q2, e2:e2, s2:s2, kill:kill};
    return e;
  endfunction

  // Monitor: compare each retiring cycle against the next expected pair; otherwise all quiet.
  always @(negedge clk_i) begin
    exp_t e;
    if (mon_en) begin
      if (retire_v_o || retire_v_o2) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_retire", 128'({retire_v_o, retire_v_o2}), 128'd0);
        end else begin
          e = sb_q.pop_front();
          chk("retire_l1", 128'({retire_v_o, retire_queue_v_o, retire_exception_o, retire_special_o}),
              128'({e.v1, e.q1, e.e1, e.s1}));
          chk("retire_l2", 128'({retire_v_o2, retire_queue_v_o2, retire_exception_o2, retire_special_o2}),
              128'({e.v2, e.q2, e.e2, e.s2}));
          chk("kill", 128'(kill_o), 128'(e.kill));
          chk("count", 128'(retire_count_o), 128'({1'b0, e.v1} + {1'b0, e.v2}));
          chk("data1", 128'(retire_data_o), 128'(wb_data_i));
          chk("data2", 128'(retire_data_o2), 128'(e.v2 ? wb_data_i2 : 64'd0));
        end
      end else begin
        chk("idle", 128'({retire_queue_v_o, retire_queue_v_o2, retire_exception_o, retire_exception_o2,
                          retire_special_o, retire_special_o2, kill_o, retire_count_o}), 128'd0);
        chk("idle_data2", 128'(retire_data_o2), 128'd0);
      end
    end
  end

  task automatic clr_in();
    issue_v_i = 1'b0; issue_v_i2 = 1'b0; issue_queue_v_i = 1'b0; issue_queue_v_i2 = 1'b0;
    issue_exception_i = '0; issue_exception_i2 = '0;
    issue_special_i = '0; issue_special_i2 = '0;
    late_exception_v_i = 1'b0; late_exception_v_i2 = 1'b0;
    late_exception_i = '0; late_exception_i2 = '0;
    flush_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc = cyc + 32'd1;
    wb_data_i  = {32'hDA7A_0001, cyc};
    wb_data_i2 = {32'hDA7A_0002, cyc};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      clr_in();
    end
  endtask

  task automatic issue(input logic v1, q1, input logic [EW-1:0] e1, input logic [SW-1:0] s1,
                       input logic v2, q2, input logic [EW-1:0] e2, input logic [SW-1:0] s2);
    step();
    clr_in();
    issue_v_i = v1; issue_queue_v_i = q1; issue_exception_i = e1; issue_special_i = s1;
    issue_v_i2 = v2; issue_queue_v_i2 = q2; issue_exception_i2 = e2; issue_special_i2 = s2;
  endtask

  task automatic late(input logic lv1, input logic [EW-1:0] le1, input logic lv2, input logic [EW-1:0] le2);
    step();
    clr_in();
    late_exception_v_i = lv1; late_exception_i = le1;
    late_exception_v_i2 = lv2; late_exception_i2 = le2;
  endtask

  initial begin
    clr_in();
    wb_data_i = '0;
    wb_data_i2 = '0;
    #2 reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 mon_en = 1'b1;
    chk("reset_instret", 128'(instret_o), 128'd0);
    #2 reset_i = 1'b1;

    // Seven good retirements, then asynchronous reset with a pair at the retire stage.
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
      sb_q.push_back(mk(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0, 1'b0));
    end
    issue(1'b1, 1'b1, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    sb_q.push_back(mk(1'b1, 1'b1, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0));
    idle(5);
    chk("instret_7", 128'(instret_o), 128'd7);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
      sb_q.push_back(mk(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0, 1'b0));
    end
    idle(1);
    chk("pre_reset_retire", 128'({retire_v_o, retire_v_o2}), 128'd3);
    #2 reset_i = 1'b0;
    sb_q.delete();
    #1;
    chk("reset_async_out", 128'({retire_v_o, retire_v_o2, retire_queue_v_o, retire_queue_v_o2,
                                 retire_exception_o, retire_exception_o2, kill_o, retire_count_o}), 128'd0);
    chk("reset_async_instret", 128'(instret_o), 128'd0);
    #10 reset_i = 1'b1;
    idle(5);

    // Ten back-to-back dual issues with first-retire latency checks.
    for (int i = 0; i < 10; i++) begin
      issue(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
      sb_q.push_back(mk(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0, 1'b0));
      if (i == 3) chk("latency_early", 128'({retire_v_o, retire_v_o2}), 128'd0);
      if (i == 4) chk("latency_first", 128'({retire_v_o, retire_v_o2, retire_count_o}), 128'({2'b11, 2'd2}));
    end
    idle(5);
    chk("instret_20", 128'(instret_o), 128'd20);

    // Lane-1 exception kills lane 2 and the four younger pairs.
    issue(1'b1, 1'b1, 16'h0004, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
    sb_q.push_back(mk(1'b1, 1'b1, 16'h0004, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1));
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
    idle(6);
    chk("instret_exc", 128'(instret_o), 128'd20);

    // Lane-1 serializer: retires and counts, lane 2 squashed.
    issue(1'b1, 1'b1, 16'h0, 8'h01, 1'b1, 1'b1, 16'h0, 8'h0);
    sb_q.push_back(mk(1'b1, 1'b1, 16'h0, 8'h01, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1));
    idle(5);
    chk("instret_spec", 128'(instret_o), 128'd21);

    // Late exception merged into lane 2 at stage 2.
    issue(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0100, 8'h0);
    sb_q.push_back(mk(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0120, 8'h0, 1'b0));
    idle(2);
    late(1'b0, 16'h0, 1'b1, 16'h0020);
    idle(4);
    chk("instret_late2", 128'(instret_o), 128'd22);

    // Late exception on lane 1 turns into a kill.
    issue(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
    sb_q.push_back(mk(1'b1, 1'b1, 16'h0008, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1));
    idle(2);
    late(1'b1, 16'h0008, 1'b0, 16'h0);
    idle(4);
    chk("instret_late1", 128'(instret_o), 128'd22);

    // Lane 2 alone, then a pair without fetch-queue entries.
    issue(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
    sb_q.push_back(mk(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0, 1'b0));
    issue(1'b1, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0, 8'h0);
    sb_q.push_back(mk(1'b1, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0));
    idle(5);
    chk("instret_l2only", 128'(instret_o), 128'd25);

    // Flush with three stages full: only the retire-stage pair retires.
    issue(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
    sb_q.push_back(mk(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0, 1'b0));
    issue(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
    issue(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
    idle(1);
    issue(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
    flush_i = 1'b1;
    idle(6);
    chk("instret_flush", 128'(instret_o), 128'd27);

    chk("sb_drained", 128'(sb_q.size()), 128'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
